// File: rtl/mcyc_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide, all behind one start/busy/done handshake.
module mcyc_alu #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         func,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               err,
  output logic [1:0]         state_dbg
);

  // Handshake: start is taken only while busy=0 (IDLE); busy stays high from the
  // accepting edge through the FIN cycle; done is high for exactly the FIN cycle,
  // and out/err are valid from then until the next operation's done edge.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_MUL = 3'd2;
  localparam logic [2:0] F_DIV = 3'd3;
  localparam logic [2:0] F_AND = 3'd4;
  localparam logic [2:0] F_OR  = 3'd5;
  localparam logic [2:0] F_XOR = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_r, b_r;
  logic [2:0]         func_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem, quo;

  logic [WIDTH:0]     add_s, sub_s;
  logic [WIDTH:0]     trial, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic               is_iter, finish;
  logic [2*WIDTH-1:0] res_out;
  logic               res_err;

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign state_dbg = state;

  // One extra bit holds the exact signed sum; overflow shows as top two bits differing.
  assign add_s = {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
  assign sub_s = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};

  // Restoring step: rem < divisor keeps diff within WIDTH+1 bits, so its MSB is the borrow.
  assign trial   = {rem, quo[WIDTH-1]};
  assign diff    = trial - {1'b0, b_r};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  assign is_iter = (func_r == F_MUL) || ((func_r == F_DIV) && (b_r != '0));
  assign finish  = (state == CALC) && (!is_iter || (cnt == CNT_LAST));

  always_comb begin
    res_out = '0;
    res_err = 1'b0;
    case (func_r)
      F_ADD: begin
        res_out = {{(WIDTH-1){add_s[WIDTH]}}, add_s};
        res_err = add_s[WIDTH] ^ add_s[WIDTH-1];
      end
      F_SUB: begin
        res_out = {{(WIDTH-1){sub_s[WIDTH]}}, sub_s};
        res_err = sub_s[WIDTH] ^ sub_s[WIDTH-1];
      end
      F_MUL: res_out = acc;
      F_DIV: begin
        if (b_r == '0) begin
          res_out = '1;
          res_err = 1'b1;
        end else begin
          res_out = {rem, quo};
        end
      end
      F_AND: res_out = {{WIDTH{1'b0}}, a_r & b_r};
      F_OR:  res_out = {{WIDTH{1'b0}}, a_r | b_r};
      F_XOR: res_out = {{WIDTH{1'b0}}, a_r ^ b_r};
      default: begin
        res_out = '0;
        res_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (finish) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      func_r <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      out    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            func_r <= func;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            rem    <= '0;
            quo    <= a;
          end
        end
        CALC: begin
          if (finish) begin
            out <= res_out;
            err <= res_err;
          end else begin
            cnt <= cnt + CW'(1);
            if (func_r == F_MUL) begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end else begin
              rem <= rem_nxt;
              quo <= {quo[WIDTH-2:0], ge};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
